rca_lsq: RTL and testbench
==========================

Name: rca_lsq

Overview:
- Single-port load/store queue sitting directly downstream of one RCA load/store operation unit (OU).
- Accepts OU memory requests, buffers them in order and issues them one at a time to the data memory port.
- Aligns, sign- or zero-extends load data and returns it to the OU as a one-cycle completion.
- Stores complete silently: no completion pulse.

Parameters:
- DEPTH, 4: queue entries; power of two, >= 2.
- XLEN, from taiga_config: data/address width (32).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous assert, active-low.
- addr  input  XLEN  OU request byte address.
- data  input  XLEN  OU store data, right-justified.
- fn3  input  3  RISC-V funct3 width/sign code.
- load  input  1  request is a load.
- store  input  1  request is a store.
- new_request  input  1  push strobe.
- lsq_full  output  1  queue holds DEPTH entries.
- load_data  output  XLEN  aligned and extended load result.
- load_complete  output  1  one-cycle pulse, load_data valid.
- mem_addr  output  XLEN  word-aligned address (addr with [1:0] = 0).
- mem_wdata  output  XLEN  lane-shifted store data.
- mem_be  output  4  byte enables.
- mem_rd  output  1  read request.
- mem_wr  output  1  write request.
- mem_ack  input  1  memory accepts the current rd/wr.
- mem_rdata  input  XLEN  read data word.
- mem_rvalid  input  1  mem_rdata valid.

Behaviour:
- Reset: count = 0, pointers = 0, state = IDLE.
- Reset values of outputs: lsq_full = 0, load_complete = 0, load_data = 0, mem_rd = 0, mem_wr = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
- Push: happens when new_request && !lsq_full. It stores {addr, data, fn3, load}.
- Push while full: the request is dropped and queue state is unchanged. The OU gates on lsq_full, so this case is a protocol error.
- lsq_full = (count == DEPTH). It is registered from count.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- FSM, IDLE:
  - Moves to ISSUE when count != 0.
  - On entering ISSUE, mem_* outputs are registered from the head entry.
  - Minimum push-to-mem_rd/mem_wr latency is 2 cycles.
- FSM, ISSUE:
  - mem_rd or mem_wr is held, with mem_addr, mem_wdata and mem_be stable, until mem_ack.
  - On ack, the head entry is popped.
  - A store goes to IDLE, or stays in ISSUE with the next head if count after the pop is nonzero (back-to-back stores, 1/cycle with mem_ack = 1).
  - A load goes to WAIT_RD, and mem_rd drops.
- FSM, WAIT_RD:
  - On mem_rvalid, the next cycle has load_complete = 1 and load_data = aligned(mem_rdata).
  - The FSM then goes to IDLE or ISSUE by the same rule as for stores.
  - Exactly one load is outstanding at a time; ordering is strict FIFO.
- mem_rvalid is ignored outside WAIT_RD.
- Store alignment by fn3 and addr[1:0] (o):
  - SB(000): be = 1<<o, wdata = {4{data[7:0]}}.
  - SH(001): be = 0011<<o, wdata = {2{data[15:0]}}.
  - SW(010): be = 1111, wdata = data.
- Load alignment: shift mem_rdata right by 8*o, then:
  - LB(000): sign-extend bit 7.
  - LH(001): sign-extend bit 15.
  - LW(010): pass through.
  - LBU(100): zero-extend byte.
  - LHU(101): zero-extend half.
- Misaligned half/word: offset bits are ignored for the access width (half uses addr[1] only, word uses none). No exception is raised.
- Reset mid-operation:
  - All entries are discarded and any pending mem_rd/mem_wr deasserts immediately.
  - A later mem_rvalid for the lost load is ignored because state = IDLE.
- A request with both load and store set is treated as a load.

Decomposition:
- Shared package rca_lsq_pkg holds:
  - fn3 constants LS_B/LS_H/LS_W/LS_BU/LS_HU (LS_BU_fn3 already lives in rca_config; reuse it).
  - lsq_entry_t struct {addr, data, fn3, load}.
  - lsq_state_t enum {IDLE, ISSUE, WAIT_RD}.
- Sub-module rca_ls_align: purely combinational.
  - Store side: fn3, offset, data -> be, wdata.
  - Load side: fn3, offset, rdata -> load_data.
  - Shared with future LSQ ports.

Test Plan:
- Load byte, sign path: push LB at addr 0x1003, mem returns rdata 0x80AB_CDEF one cycle after ack -> mem_addr = 0x1000, mem_rd held until ack; load_complete one cycle after rvalid with load_data = 0xFFFF_FF80.
- Load unsigned: push LBU at 0x1003, same rdata -> load_data = 0x0000_0080. Push LHU at 0x1002, same rdata -> 0x0000_80AB.
- Stores: push SB data 0x55 at 0x2001 -> mem_be = 0010, mem_wdata = 0x5555_5555, no load_complete. Push SH at 0x2002 -> be = 1100.
- Full/back-pressure: mem_ack = 0, push 4 stores -> lsq_full = 1 the cycle after the 4th push. 5th push dropped. Release ack -> four writes in order, lsq_full = 0 the cycle after the first ack.
- Ordering: push store 0x3000, then LW 0x3000 -> write issued and acked before mem_rd; load_complete returns rdata unchanged.
- Reset mid-load: assert rst low in WAIT_RD, release, then pulse mem_rvalid -> no load_complete; queue empty; lsq_full = 0.

Source files
------------

// File: rtl/rca_lsq_pkg.sv
// rtl/rca_lsq_pkg.sv - shared types and constants for the RCA load/store queue
package rca_lsq_pkg;

    localparam int LSQ_XLEN = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef struct packed {
        logic [LSQ_XLEN-1:0] addr;
        logic [LSQ_XLEN-1:0] data;
        logic [2:0]          fn3;
        logic                load;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } lsq_state_t;

    // Byte offset actually used for an access: halves keep addr[1], words keep none.
    function automatic logic [1:0] eff_offset(input logic [2:0] fn3, input logic [1:0] off);
        case (fn3[1:0])
            2'b00:   return off;
            2'b01:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rca_ls_align.sv
// rtl/rca_ls_align.sv - byte-lane steering for stores and extraction/extension for loads
module rca_ls_align
    import rca_lsq_pkg::*;
(
    input  logic [2:0]          st_fn3_i,
    input  logic [1:0]          st_offset_i,
    input  logic [LSQ_XLEN-1:0] st_data_i,
    output logic [3:0]          be_o,
    output logic [LSQ_XLEN-1:0] wdata_o,
    input  logic [2:0]          ld_fn3_i,
    input  logic [1:0]          ld_offset_i,
    input  logic [LSQ_XLEN-1:0] rdata_i,
    output logic [LSQ_XLEN-1:0] ldata_o
);

    logic [1:0]          st_off;
    logic [1:0]          ld_off;
    logic [LSQ_XLEN-1:0] shifted;

    assign st_off  = eff_offset(st_fn3_i, st_offset_i);
    assign ld_off  = eff_offset(ld_fn3_i, ld_offset_i);
    assign shifted = rdata_i >> {ld_off, 3'b000};

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
        case (st_fn3_i)
            LS_B: begin
                be_o    = 4'b0001 << st_off;
                wdata_o = {4{st_data_i[7:0]}};
            end
            LS_H: begin
                be_o    = 4'b0011 << st_off;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ldata_o = shifted;
        case (ld_fn3_i)
            LS_B:    ldata_o = {{(LSQ_XLEN-8){shifted[7]}}, shifted[7:0]};
            LS_H:    ldata_o = {{(LSQ_XLEN-16){shifted[15]}}, shifted[15:0]};
            LS_BU:   ldata_o = {{(LSQ_XLEN-8){1'b0}}, shifted[7:0]};
            LS_HU:   ldata_o = {{(LSQ_XLEN-16){1'b0}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/rca_lsq.sv
// rtl/rca_lsq.sv - in-order load/store queue between the RCA LS unit and the data memory port
module rca_lsq
    import rca_lsq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = LSQ_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      fn3,
    input  logic            load,
    input  logic            store,
    input  logic            new_request,
    output logic            lsq_full,
    output logic [XLEN-1:0] load_data,
    output logic            load_complete,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic            mem_rd,
    output logic            mem_wr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    lsq_entry_t      entries_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   nxt_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    lsq_state_t      state_q;
    lsq_state_t      state_d;
    logic            full_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q;
    logic [XLEN-1:0] mem_wdata_d;
    logic [3:0]      mem_be_q;
    logic [3:0]      mem_be_d;
    logic            mem_rd_q;
    logic            mem_rd_d;
    logic            mem_wr_q;
    logic            mem_wr_d;
    logic            load_complete_q;
    logic            load_complete_d;
    logic [XLEN-1:0] load_data_q;
    logic [XLEN-1:0] load_data_d;
    logic [2:0]      cur_fn3_q;
    logic [2:0]      cur_fn3_d;
    logic [1:0]      cur_off_q;
    logic [1:0]      cur_off_d;
    logic            push;
    logic            pop;
    logic            start;
    lsq_entry_t      sel_entry;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    // A strobe with neither load nor store set carries no memory operation.
    assign push    = new_request && !full_q && (load || store);
    assign nxt_ptr = rd_ptr_q + PW'(1);

    // In ISSUE the head is being popped this cycle, so the next issue comes from head+1.
    assign sel_entry = (state_q == ISSUE) ? entries_q[nxt_ptr] : entries_q[rd_ptr_q];

    rca_ls_align u_align (
        .st_fn3_i    (sel_entry.fn3),
        .st_offset_i (sel_entry.addr[1:0]),
        .st_data_i   (sel_entry.data),
        .be_o        (st_be),
        .wdata_o     (st_wdata),
        .ld_fn3_i    (cur_fn3_q),
        .ld_offset_i (cur_off_q),
        .rdata_i     (mem_rdata),
        .ldata_o     (ld_data)
    );

    always_comb begin
        state_d         = state_q;
        pop             = 1'b0;
        start           = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_be_d        = mem_be_q;
        mem_rd_d        = mem_rd_q;
        mem_wr_d        = mem_wr_q;
        load_complete_d = 1'b0;
        load_data_d     = load_data_q;
        cur_fn3_d       = cur_fn3_q;
        cur_off_d       = cur_off_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = ISSUE;
                    start   = 1'b1;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    pop = 1'b1;
                    if (mem_rd_q) begin
                        state_d  = WAIT_RD;
                        mem_rd_d = 1'b0;
                    end else begin
                        mem_wr_d = 1'b0;
                        if (count_q != CW'(1)) start = 1'b1;
                        else state_d = IDLE;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    load_complete_d = 1'b1;
                    load_data_d     = ld_data;
                    if (count_q != '0) begin
                        state_d = ISSUE;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            mem_addr_d  = {sel_entry.addr[XLEN-1:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_be_d    = st_be;
            mem_rd_d    = sel_entry.load;
            mem_wr_d    = !sel_entry.load;
            cur_fn3_d   = sel_entry.fn3;
            cur_off_d   = sel_entry.addr[1:0];
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            full_q          <= 1'b0;
            state_q         <= IDLE;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_be_q        <= '0;
            mem_rd_q        <= 1'b0;
            mem_wr_q        <= 1'b0;
            load_complete_q <= 1'b0;
            load_data_q     <= '0;
            cur_fn3_q       <= '0;
            cur_off_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= nxt_ptr;
            count_q         <= count_d;
            full_q          <= (count_d == CW'(DEPTH));
            state_q         <= state_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_be_q        <= mem_be_d;
            mem_rd_q        <= mem_rd_d;
            mem_wr_q        <= mem_wr_d;
            load_complete_q <= load_complete_d;
            load_data_q     <= load_data_d;
            cur_fn3_q       <= cur_fn3_d;
            cur_off_q       <= cur_off_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries_q[wr_ptr_q] <= '{addr: addr, data: data, fn3: fn3, load: load};
    end

    assign lsq_full      = full_q;
    assign load_data     = load_data_q;
    assign load_complete = load_complete_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    assign mem_rd        = mem_rd_q;
    assign mem_wr        = mem_wr_q;

endmodule

// File: tb/tb_rca_lsq.sv
// tb/tb_rca_lsq.sv - randomized scoreboard bench for rca_lsq against a word-memory reference model
module tb_rca_lsq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, data;
    logic [2:0]  fn3;
    logic        load, store, new_request;
    logic        lsq_full, load_complete, mem_rd, mem_wr;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    rca_lsq #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3),
        .load(load), .store(store), .new_request(new_request),
        .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    typedef struct {
        logic [1:0]  kind;   // {rd, wr}
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
    } mem_op_t;

    mem_op_t     exp_mem_q[$];
    logic [31:0] exp_ld_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];
    logic [2:0]  ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    int n_checks = 0;
    int n_pass   = 0;
    int n_pushed = 0;
    int n_acked  = 0;
    bit hold_ack = 1'b0;
    int ack_pct  = 100;
    int rv_fix   = 0;
    int rv_timer = -1;
    logic [31:0] rv_data;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] w);
        if (w == 32'h0000_0400) return 32'h80AB_CDEF;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] w);
        return dev_mem.exists(w) ? dev_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
        logic [31:0] w, v;
        int sh;
        w = ref_rd(a >> 2);
        case (f)
            3'b000, 3'b100: sh = int'(a % 4) * 8;
            3'b001, 3'b101: sh = int'((a % 4) & 2) * 8;
            default:        sh = 0;
        endcase
        v = w >> sh;
        case (f)
            3'b000:  begin v = v & 32'hFF;   return (v >= 128)   ? v + 32'hFFFF_FF00 : v; end
            3'b001:  begin v = v & 32'hFFFF; return (v >= 32768) ? v + 32'hFFFF_0000 : v; end
            3'b100:  return v & 32'hFF;
            3'b101:  return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                               output logic [3:0] be, output logic [31:0] wd);
        logic [31:0] w;
        int o;
        o = int'(a % 4);
        case (f)
            3'b000:  begin be = 4'(1 << o);       wd = (d & 32'hFF) * 32'h0101_0101; end
            3'b001:  begin be = 4'(3 << (o & 2)); wd = (d & 32'hFFFF) * 32'h0001_0001; end
            default: begin be = 4'hF;             wd = d; end
        endcase
        w = ref_rd(a >> 2);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[a >> 2] = w;
    endtask

    // Called at negedge+1; returns at negedge+1 one cycle after the push edge.
    task automatic send(input bit ld, input bit st, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
        mem_op_t     op;
        logic [3:0]  be;
        logic [31:0] wd;
        int          guard = 0;
        while (lsq_full === 1'b1 && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 2000) begin
            check("full_wait_timeout", {31'b0, lsq_full}, 32'h0);
            return;
        end
        addr = a; data = d; fn3 = f; load = ld; store = st; new_request = 1'b1;
        if (ld) begin
            op = '{kind: 2'b10, a: a & ~32'h3, be: 4'h0, wd: 32'h0};
            exp_ld_q.push_back(model_load(f, a));
        end else begin
            model_store(f, a, d, be, wd);
            op = '{kind: 2'b01, a: a & ~32'h3, be: be, wd: wd};
        end
        exp_mem_q.push_back(op);
        n_pushed++;
        @(negedge clk); #1;
        new_request = 1'b0; load = 1'b0; store = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_mem_q.size() != 0 || exp_ld_q.size() != 0 || rv_timer >= 0) && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        check("drain_pending", exp_mem_q.size() + exp_ld_q.size(), 32'h0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Memory responder plus monitor: everything here runs on the falling edge.
    initial begin : monitor
        bit          held = 1'b0;
        bit          pending_ack = 1'b0;
        mem_op_t     h_op;
        mem_op_t     op;
        logic [31:0] w;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        h_op = '{kind: 2'b00, a: 32'h0, be: 4'h0, wd: 32'h0};
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (rv_timer > 0) begin
                rv_timer--;
                if (rv_timer == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv_data;
                    rv_timer   = -1;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                mem_rvalid = 1'b1;
            end
            if (pending_ack) n_acked++;
            pending_ack = 1'b0;
            mem_ack     = 1'b0;
            if (rst !== 1'b1) begin
                held = 1'b0;
            end else begin
                if (exp_ld_q.size() == 0) check("no_spurious_complete", {31'b0, load_complete}, 32'h0);
                else if (load_complete) check("load_data", load_data, exp_ld_q.pop_front());
                check("lsq_full", {31'b0, lsq_full}, {31'b0, (n_pushed - n_acked) == 4});
                if (mem_rd || mem_wr) begin
                    if (held) begin
                        check("hold_kind", {30'b0, mem_rd, mem_wr}, {30'b0, h_op.kind});
                        check("hold_addr", mem_addr, h_op.a);
                        if (h_op.kind == 2'b01) check("hold_wdata", mem_wdata, h_op.wd);
                    end else if (exp_mem_q.size() == 0) begin
                        check("no_spurious_mem", {30'b0, mem_rd, mem_wr}, 32'h0);
                    end else begin
                        op = exp_mem_q.pop_front();
                        check("mem_kind", {30'b0, mem_rd, mem_wr}, {30'b0, op.kind});
                        check("mem_addr", mem_addr, op.a);
                        if (op.kind == 2'b01) begin
                            check("mem_be", {28'b0, mem_be}, {28'b0, op.be});
                            check("mem_wdata", mem_wdata, op.wd);
                        end
                        h_op = op;
                    end
                    if (!hold_ack && $urandom_range(0, 99) < ack_pct) begin
                        mem_ack     = 1'b1;
                        pending_ack = 1'b1;
                        held        = 1'b0;
                        if (mem_wr) begin
                            w = dev_rd(mem_addr >> 2);
                            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                            dev_mem[mem_addr >> 2] = w;
                        end else begin
                            rv_data  = dev_rd(mem_addr >> 2);
                            rv_timer = (rv_fix > 0) ? rv_fix : int'($urandom_range(1, 3));
                        end
                    end else begin
                        held = 1'b1;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin : main
        int          k;
        int          g;
        bit          ld, st;
        logic [2:0]  f;
        rst = 1'b0; new_request = 1'b0; addr = '0; data = '0; fn3 = '0; load = 1'b0; store = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_lsq_full",      {31'b0, lsq_full},      32'h0);
        check("rst_load_complete", {31'b0, load_complete}, 32'h0);
        check("rst_load_data",     load_data,              32'h0);
        check("rst_mem_rd",        {31'b0, mem_rd},        32'h0);
        check("rst_mem_wr",        {31'b0, mem_wr},        32'h0);
        check("rst_mem_be",        {28'b0, mem_be},        32'h0);
        check("rst_mem_addr",      mem_addr,               32'h0);
        check("rst_mem_wdata",     mem_wdata,              32'h0);
        rst = 1'b1;
        @(negedge clk); #1;

        // Directed loads/stores from the word 0x80ABCDEF at 0x1000
        send(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0);
        check("rd_latency_1", {31'b0, mem_rd}, 32'h0);
        @(negedge clk); #1;
        check("rd_latency_2", {31'b0, mem_rd}, 32'h1);
        send(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0);
        send(1'b1, 1'b0, 3'b101, 32'h1002, 32'h0);
        send(1'b0, 1'b1, 3'b000, 32'h2001, 32'h55);
        send(1'b0, 1'b1, 3'b001, 32'h2002, 32'hBEEF);
        send(1'b0, 1'b1, 3'b010, 32'h3000, 32'h1234_5678);
        send(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0);
        drain();

        // Back-pressure: fill with ack held off, then try a dropped fifth push
        hold_ack = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 3'b010, 32'h6000 + 32'(4 * i), $urandom);
        check("full_after_4", {31'b0, lsq_full}, 32'h1);
        addr = 32'h6100; data = 32'hDEAD_BEEF; fn3 = 3'b010; store = 1'b1; new_request = 1'b1;
        @(negedge clk); #1;
        new_request = 1'b0; store = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("full_held", {31'b0, lsq_full}, 32'h1);
        hold_ack = 1'b0;
        drain();

        // Randomized mix
        ack_pct = 60;
        for (int n = 0; n < 200; n++) begin
            k = int'($urandom_range(0, 9));
            if (k < 4)      begin ld = 1'b1; st = 1'b0; end
            else if (k < 9) begin ld = 1'b0; st = 1'b1; end
            else            begin ld = 1'b1; st = 1'b1; end
            f = ld ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            send(ld, st, f, 32'h4000 + 32'($urandom_range(0, 63)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #0;
        end
        drain();

        // Reset while a load waits for its data
        ack_pct = 100;
        rv_fix  = 6;
        send(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0);
        g = 0;
        while (rv_timer < 0 && g < 100) begin
            @(negedge clk); #1;
            g++;
        end
        check("rd_ack_seen", {31'b0, rv_timer >= 0}, 32'h1);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_mid_mem_rd",   {31'b0, mem_rd},   32'h0);
        check("rst_mid_mem_wr",   {31'b0, mem_wr},   32'h0);
        check("rst_mid_lsq_full", {31'b0, lsq_full}, 32'h0);
        exp_mem_q.delete();
        exp_ld_q.delete();
        n_pushed = 0;
        n_acked  = 0;
        @(negedge clk); #1;
        rst    = 1'b1;
        rv_fix = 0;
        repeat (10) @(negedge clk);
        #1;
        check("post_rst_mem_rd", {31'b0, mem_rd}, 32'h0);
        send(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
